// File: rtl/execute.sv
// Execute stage of the in-order RV64 pipeline: ALU, address generation and
// branch resolution, registered into one valid/ready slot with a redirect pulse.

package common;
  typedef logic [63:0] u64;
  typedef logic [63:0] word_t;
endpackage

package pipes;
  typedef enum logic [4:0] {
    OP_NOP   = 5'd0,
    OP_ADD   = 5'd1,
    OP_ADDI  = 5'd2,
    OP_SUB   = 5'd3,
    OP_OR    = 5'd4,
    OP_ORI   = 5'd5,
    OP_AND   = 5'd6,
    OP_ANDI  = 5'd7,
    OP_XOR   = 5'd8,
    OP_XORI  = 5'd9,
    OP_LUI   = 5'd10,
    OP_AUIPC = 5'd11,
    OP_LD    = 5'd12,
    OP_SD    = 5'd13,
    OP_JAL   = 5'd14,
    OP_JALR  = 5'd15,
    OP_BEQ   = 5'd16
  } decode_op_t;
endpackage

module execute
  import common::*;
  import pipes::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  decode_op_t  in_op,
  input  u64          in_pc,
  input  word_t       in_srca,
  input  word_t       in_srcb,
  input  word_t       in_rd1,
  input  word_t       in_rd2,
  input  word_t       in_imm,
  input  logic [4:0]  in_dst,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output decode_op_t  out_op,
  output u64          out_pc,
  output logic [4:0]  out_dst,
  output word_t       out_result,
  output word_t       out_store_data,
  output logic        out_wen,
  output logic        redirect_valid,
  output u64          redirect_pc,
  output logic [31:0] exec_count
);

  logic        r_out_valid;
  decode_op_t  r_out_op;
  u64          r_out_pc;
  logic [4:0]  r_out_dst;
  word_t       r_out_result;
  word_t       r_out_store_data;
  logic        r_out_wen;
  logic        r_redirect_valid;
  u64          r_redirect_pc;
  logic [31:0] r_exec_count;

  word_t       w_alu;
  logic        w_wen;
  logic        w_taken;
  u64          w_target;
  word_t       w_store_data;
  logic        w_accept;
  logic        w_drain;

  always_comb begin
    w_alu        = '0;
    w_wen        = 1'b0;
    w_taken      = 1'b0;
    w_target     = in_pc + in_imm;
    w_store_data = '0;
    unique case (in_op)
      OP_ADD, OP_ADDI, OP_LUI, OP_AUIPC, OP_LD, OP_JAL: begin
        w_alu = in_srca + in_srcb;
        w_wen = 1'b1;
        w_taken = (in_op == OP_JAL);
      end
      OP_JALR: begin
        w_alu    = in_srca + in_srcb;
        w_wen    = 1'b1;
        w_taken  = 1'b1;
        w_target = (in_rd1 + in_imm) & ~64'h1;
      end
      OP_SD: begin
        w_alu        = in_srca + in_srcb;
        w_store_data = in_rd2;
      end
      OP_SUB: begin
        w_alu = in_srca - in_srcb;
        w_wen = 1'b1;
      end
      OP_OR, OP_ORI: begin
        w_alu = in_srca | in_srcb;
        w_wen = 1'b1;
      end
      OP_AND, OP_ANDI: begin
        w_alu = in_srca & in_srcb;
        w_wen = 1'b1;
      end
      OP_XOR, OP_XORI: begin
        w_alu = in_srca ^ in_srcb;
        w_wen = 1'b1;
      end
      OP_BEQ: w_taken = (in_rd1 == in_rd2);
      default: w_alu = '0;
    endcase
    if (in_dst == 5'd0) w_wen = 1'b0;
  end

  // A pending redirect blocks accept so the wrong-path instruction never enters.
  assign in_ready = !r_redirect_valid && !flush && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_drain  = r_out_valid && out_ready && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid      <= 1'b0;
      r_out_op         <= OP_NOP;
      r_out_pc         <= '0;
      r_out_dst        <= '0;
      r_out_result     <= '0;
      r_out_store_data <= '0;
      r_out_wen        <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_exec_count     <= '0;
    end else begin
      r_redirect_valid <= w_accept && w_taken;
      if (w_drain) r_exec_count <= r_exec_count + 32'd1;
      if (flush) begin
        r_out_valid <= 1'b0;
      end else if (w_accept) begin
        r_out_valid      <= 1'b1;
        r_out_op         <= in_op;
        r_out_pc         <= in_pc;
        r_out_dst        <= in_dst;
        r_out_result     <= w_alu;
        r_out_store_data <= w_store_data;
        r_out_wen        <= w_wen;
        if (w_taken) r_redirect_pc <= w_target;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid      = r_out_valid;
  assign out_op         = r_out_op;
  assign out_pc         = r_out_pc;
  assign out_dst        = r_out_dst;
  assign out_result     = r_out_result;
  assign out_store_data = r_out_store_data;
  assign out_wen        = r_out_wen;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign exec_count     = r_exec_count;

endmodule

// File: tb/tb_execute.sv
// Directed plus short random bench for the execute stage; a reference model
// predicts accepts and results into a scoreboard checked at the output slot.

module tb_execute;
  import common::*;
  import pipes::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  decode_op_t  in_op = OP_NOP;
  u64          in_pc = '0;
  word_t       in_srca = '0, in_srcb = '0, in_rd1 = '0, in_rd2 = '0, in_imm = '0;
  logic [4:0]  in_dst = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  decode_op_t  out_op;
  u64          out_pc;
  logic [4:0]  out_dst;
  word_t       out_result, out_store_data;
  logic        out_wen;
  logic        redirect_valid;
  u64          redirect_pc;
  logic [31:0] exec_count;

  execute dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_pc(in_pc),
    .in_srca(in_srca), .in_srcb(in_srcb), .in_rd1(in_rd1), .in_rd2(in_rd2),
    .in_imm(in_imm), .in_dst(in_dst), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_pc(out_pc),
    .out_dst(out_dst), .out_result(out_result), .out_store_data(out_store_data),
    .out_wen(out_wen), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .exec_count(exec_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    decode_op_t op;
    u64         pc;
    logic [4:0] dst;
    word_t      res;
    word_t      sd;
    logic       wen;
  } exp_t;

  exp_t        sb[$];
  int          vecs = 0;
  int          errs = 0;
  logic        exp_rv = 1'b0;
  u64          exp_rpc = '0;
  logic [31:0] exp_cnt = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model();
    exp_t e;
    e.op  = in_op;
    e.pc  = in_pc;
    e.dst = in_dst;
    e.sd  = (in_op == OP_SD) ? in_rd2 : 64'd0;
    case (in_op)
      OP_ADD, OP_ADDI, OP_LUI, OP_AUIPC, OP_LD, OP_SD, OP_JAL, OP_JALR: e.res = in_srca + in_srcb;
      OP_SUB:          e.res = in_srca + (~in_srcb + 64'd1);
      OP_OR, OP_ORI:   e.res = in_srca | in_srcb;
      OP_AND, OP_ANDI: e.res = in_srca & in_srcb;
      OP_XOR, OP_XORI: e.res = in_srca ^ in_srcb;
      default:         e.res = 64'd0;
    endcase
    e.wen = (in_dst != 5'd0) &&
            (in_op inside {OP_ADD, OP_SUB, OP_OR, OP_AND, OP_XOR, OP_ADDI, OP_ORI, OP_ANDI,
                           OP_XORI, OP_LUI, OP_AUIPC, OP_LD, OP_JAL, OP_JALR});
    return e;
  endfunction

  // Checks the current cycle against the model, then advances the model past the edge.
  task automatic tick();
    logic m_rdy, hs, acc, tk;
    u64   tgt;
    @(negedge clk);
    m_rdy = !exp_rv && !flush && (sb.size() == 0 || out_ready);
    chk("out_valid", {63'd0, out_valid}, {63'd0, sb.size() != 0});
    chk("in_ready", {63'd0, in_ready}, {63'd0, m_rdy});
    chk("redirect_valid", {63'd0, redirect_valid}, {63'd0, exp_rv});
    if (exp_rv) chk("redirect_pc", redirect_pc, exp_rpc);
    chk("exec_count", {32'd0, exec_count}, {32'd0, exp_cnt});
    if (sb.size() != 0) begin
      chk("out_op", {59'd0, out_op}, {59'd0, sb[0].op});
      chk("out_pc", out_pc, sb[0].pc);
      chk("out_dst", {59'd0, out_dst}, {59'd0, sb[0].dst});
      chk("out_result", out_result, sb[0].res);
      chk("out_store_data", out_store_data, sb[0].sd);
      chk("out_wen", {63'd0, out_wen}, {63'd0, sb[0].wen});
    end
    hs  = (sb.size() != 0) && out_ready && !flush;
    acc = in_valid && m_rdy;
    tk  = (in_op == OP_JAL) || (in_op == OP_JALR) || (in_op == OP_BEQ && in_rd1 == in_rd2);
    tgt = (in_op == OP_JALR) ? ((in_rd1 + in_imm) & {{63{1'b1}}, 1'b0}) : (in_pc + in_imm);
    if (flush) begin
      sb.delete();
      exp_rv = 1'b0;
    end else begin
      if (hs) begin
        void'(sb.pop_front());
        exp_cnt = exp_cnt + 32'd1;
      end
      if (acc) sb.push_back(model());
      exp_rv = acc && tk;
      if (acc && tk) exp_rpc = tgt;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input decode_op_t op, input u64 pc, input word_t a, input word_t b,
                       input word_t r1, input word_t r2, input word_t imm, input logic [4:0] dst);
    in_valid = 1'b1; in_op = op; in_pc = pc; in_srca = a; in_srcb = b;
    in_rd1 = r1; in_rd2 = r2; in_imm = imm; in_dst = dst;
  endtask

  decode_op_t  ops [17] = '{OP_NOP, OP_ADD, OP_ADDI, OP_SUB, OP_OR, OP_ORI, OP_AND, OP_ANDI,
                            OP_XOR, OP_XORI, OP_LUI, OP_AUIPC, OP_LD, OP_SD, OP_JAL, OP_JALR, OP_BEQ};
  logic [31:0] cnt_snap;

  initial begin
    #12;
    chk("rst out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst redirect_valid", {63'd0, redirect_valid}, 64'd0);
    chk("rst redirect_pc", redirect_pc, 64'd0);
    chk("rst out_result", out_result, 64'd0);
    chk("rst out_store_data", out_store_data, 64'd0);
    chk("rst out_wen", {63'd0, out_wen}, 64'd0);
    chk("rst out_pc", out_pc, 64'd0);
    chk("rst out_dst", {59'd0, out_dst}, 64'd0);
    chk("rst out_op", {59'd0, out_op}, 64'd0);
    chk("rst exec_count", {32'd0, exec_count}, 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // ADD wraps to zero
    out_ready = 1'b1;
    drive(OP_ADD, 64'h100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, 0, 5'd3);
    tick();
    in_valid = 1'b0;
    chk("add out_valid", {63'd0, out_valid}, 64'd1);
    chk("add result", out_result, 64'd0);
    chk("add wen", {63'd0, out_wen}, 64'd1);
    tick();
    chk("add count", {32'd0, exec_count}, 64'd1);

    // Taken BEQ with a wrong-path ADDI held behind it
    drive(OP_BEQ, 64'h8000_0000, 0, 0, 64'd5, 64'd5, 64'h10, 5'd0);
    tick();
    drive(OP_ADDI, 64'h8000_0004, 64'd7, 64'd1, 0, 0, 64'd1, 5'd4);
    chk("beq redirect", {63'd0, redirect_valid}, 64'd1);
    chk("beq target", redirect_pc, 64'h8000_0010);
    chk("beq in_ready", {63'd0, in_ready}, 64'd0);
    chk("beq wen", {63'd0, out_wen}, 64'd0);
    tick();
    in_valid = 1'b0;
    chk("beq pulse end", {63'd0, redirect_valid}, 64'd0);
    drive(OP_BEQ, 64'h8000_0000, 0, 0, 64'd5, 64'd6, 64'h10, 5'd0);
    tick();
    in_valid = 1'b0;
    chk("beq nt redirect", {63'd0, redirect_valid}, 64'd0);
    tick();

    // JALR clears bit 0 of the target, links pc+4
    drive(OP_JALR, 64'h200, 64'h200, 64'd4, 64'h1001, 0, 64'd2, 5'd1);
    tick();
    in_valid = 1'b0;
    chk("jalr target", redirect_pc, 64'h1002);
    chk("jalr link", out_result, 64'h204);
    chk("jalr wen", {63'd0, out_wen}, 64'd1);
    tick();

    // Backpressure then drain with same-cycle reload
    drive(OP_ADD, 64'h300, 64'd10, 64'd20, 0, 0, 0, 5'd5);
    tick();
    out_ready = 1'b0;
    drive(OP_XOR, 64'h304, 64'hF0F0, 64'h0FF0, 0, 0, 0, 5'd6);
    cnt_snap = exp_cnt;
    repeat (3) tick();
    chk("stall count", {32'd0, exec_count}, {32'd0, cnt_snap});
    chk("stall result", out_result, 64'd30);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("reload valid", {63'd0, out_valid}, 64'd1);
    chk("reload op", {59'd0, out_op}, {59'd0, OP_XOR});
    tick();

    // Flush a stalled SD while a new instruction is presented
    drive(OP_SD, 64'h400, 64'h1000, 64'h8, 0, 64'hDEAD, 64'h8, 5'd0);
    tick();
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("sd data", out_store_data, 64'hDEAD);
    chk("sd wen", {63'd0, out_wen}, 64'd0);
    tick();
    cnt_snap = exp_cnt;
    drive(OP_ADD, 64'h404, 64'd1, 64'd1, 0, 0, 0, 5'd7);
    flush = 1'b1;
    out_ready = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush valid", {63'd0, out_valid}, 64'd0);
    chk("flush count", {32'd0, exec_count}, {32'd0, cnt_snap});
    tick();

    // Random mix under random backpressure
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(3) != 0)
        drive(ops[$urandom_range(16)], {32'd0, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
              {60'd0, 4'($urandom_range(3))}, {60'd0, 4'($urandom_range(3))},
              {32'd0, $urandom}, 5'($urandom_range(3)));
      else
        in_valid = 1'b0;
      out_ready = ($urandom_range(3) != 0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();

    // Asynchronous reset during a JAL redirect cycle
    drive(OP_JAL, 64'h1000, 64'h1000, 64'd4, 0, 0, 64'h40, 5'd1);
    tick();
    in_valid = 1'b0;
    chk("jal redirect", {63'd0, redirect_valid}, 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("async out_valid", {63'd0, out_valid}, 64'd0);
    chk("async redirect", {63'd0, redirect_valid}, 64'd0);
    chk("async count", {32'd0, exec_count}, 64'd0);
    sb.delete();
    exp_rv = 1'b0;
    exp_cnt = '0;
    @(negedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
